// File: rtl/col_histogram.sv
// Per-column histogram of colour-matched pixels for an 80x60 raster.
// Each accepted pixel updates a saturating column counter. The column index
// is presented one cycle after acceptance and the updated count one cycle
// later still. At frame end the block waits for the output pipeline to
// drain, pulses start, then zeroes the counter array before accepting the
// next frame.
module col_histogram #(
  parameter int NUM_COLS = 80,
  parameter int NUM_ROWS = 60,
  parameter int COL_W    = 7,
  parameter int ROW_W    = 6,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             px_valid,
  input  logic             px_match,
  input  logic [COL_W-1:0] px_col,
  input  logic [ROW_W-1:0] px_row,
  output logic [COL_W-1:0] px_pos_ret,
  output logic [CNT_W-1:0] reg_histograma,
  output logic             start,
  output logic             busy,
  output logic             drop_err
);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(NUM_COLS);

  logic [1:0]       r_state;
  logic             r_flush_cnt;
  logic [COL_W-1:0] r_clr_idx;
  logic [CNT_W-1:0] r_cnt [NUM_COLS];
  logic [CNT_W-1:0] r_new_s1;
  logic             r_s1_vld;

  logic             w_col_ok;
  logic             w_accept;
  logic             w_last_px;
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_new;

  assign w_col_ok  = (px_col < COL_LIM);
  assign w_accept  = (r_state == S_ACCUM) && px_valid && w_col_ok;
  assign w_last_px = (px_col == LAST_COL) && (px_row == LAST_ROW);

  assign busy  = (r_state != S_ACCUM);
  assign start = (r_state == S_START);

  // Combinational read of the addressed counter; out-of-range columns read 0.
  always_comb begin
    w_cur = '0;
    if (w_col_ok) begin
      w_cur = r_cnt[px_col];
    end
  end

  // Saturating increment: a full counter stays full instead of wrapping.
  always_comb begin
    w_new = w_cur;
    if (px_match && (w_cur != '1)) begin
      w_new = w_cur + 1'b1;
    end
  end

  // Frame sequencing: accumulate, drain the output pipeline, pulse, clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_ACCUM;
      r_flush_cnt <= 1'b0;
      r_clr_idx   <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_flush_cnt <= 1'b0;
          r_clr_idx   <= '0;
          if (w_accept && w_last_px) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt) begin
            r_flush_cnt <= 1'b0;
            r_state     <= S_START;
          end else begin
            r_flush_cnt <= 1'b1;
          end
        end
        S_START: begin
          r_clr_idx <= '0;
          r_state   <= S_CLEAR;
        end
        S_CLEAR: begin
          if (r_clr_idx == LAST_COL) begin
            r_clr_idx <= '0;
            r_state   <= S_ACCUM;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_state <= S_ACCUM;
        end
      endcase
    end
  end

  // Counter array: written on the accepting edge, so a following pixel to
  // the same column already reads the updated value without forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
        if (w_accept && (px_col == COL_W'(i))) begin
          r_cnt[i] <= w_new;
        end else if ((r_state == S_CLEAR) && (r_clr_idx == COL_W'(i))) begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Output pipeline: index one cycle after acceptance, count two cycles after.
  // Outputs hold between accepted pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_pos_ret     <= '0;
      r_new_s1       <= '0;
      r_s1_vld       <= 1'b0;
      reg_histograma <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        px_pos_ret <= px_col;
        r_new_s1   <= w_new;
      end
      if (r_s1_vld) begin
        reg_histograma <= r_new_s1;
      end
    end
  end

  // Sticky flag for valid pixels that arrive while the frame is being closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err <= 1'b0;
    end else if (px_valid && busy) begin
      drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_col_histogram.sv
// Directed bench for col_histogram.
module tb_col_histogram;

  logic       clk;
  logic       rst;
  logic       px_valid;
  logic       px_match;
  logic [6:0] px_col;
  logic [5:0] px_row;
  logic [6:0] px_pos_ret;
  logic [5:0] reg_histograma;
  logic       start;
  logic       busy;
  logic       drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  col_histogram #(
    .NUM_COLS(80),
    .NUM_ROWS(60),
    .COL_W   (7),
    .ROW_W   (6),
    .CNT_W   (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .px_valid      (px_valid),
    .px_match      (px_match),
    .px_col        (px_col),
    .px_row        (px_row),
    .px_pos_ret    (px_pos_ret),
    .reg_histograma(reg_histograma),
    .start         (start),
    .busy          (busy),
    .drop_err      (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic v, input logic m, input logic [6:0] c, input logic [5:0] r);
    px_valid = v;
    px_match = m;
    px_col   = c;
    px_row   = r;
  endtask

  task automatic idle;
    set_px(1'b0, 1'b0, 7'd0, 6'd0);
  endtask

  task automatic apply_reset;
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b0;
    #3;
    n_checks++;
    if (px_pos_ret !== 7'd0 || reg_histograma !== 6'd0 || start !== 1'b0 ||
        busy !== 1'b0 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pos=%0d hist=%0d start=%b busy=%b drop=%b expected all 0",
               px_pos_ret, reg_histograma, start, busy, drop_err);
    end
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || start !== 1'b0 || reg_histograma !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b start=%b hist=%0d expected 0 0 0",
               busy, start, reg_histograma);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_px(1'b1, 1'b1, 7'd5, 6'd0);
    step();
    n_checks++;
    if (px_pos_ret !== 7'd5 || reg_histograma !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_c1: got pos=%0d hist=%0d expected pos=5 hist=0", px_pos_ret, reg_histograma);
    end
    set_px(1'b1, 1'b1, 7'd5, 6'd1);
    step();
    n_checks++;
    if (px_pos_ret !== 7'd5 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL b2b_c2: got pos=%0d hist=%0d expected pos=5 hist=1", px_pos_ret, reg_histograma);
    end
    set_px(1'b1, 1'b1, 7'd5, 6'd2);
    step();
    n_checks++;
    if (px_pos_ret !== 7'd5 || reg_histograma !== 6'd2) begin
      n_fail++;
      $display("FAIL b2b_c3: got pos=%0d hist=%0d expected pos=5 hist=2", px_pos_ret, reg_histograma);
    end
    idle();
    step();
    n_checks++;
    if (px_pos_ret !== 7'd5 || reg_histograma !== 6'd3) begin
      n_fail++;
      $display("FAIL b2b_c4: got pos=%0d hist=%0d expected pos=5 hist=3", px_pos_ret, reg_histograma);
    end
    // A non-matching pixel on another column reports that column's unchanged count.
    set_px(1'b1, 1'b0, 7'd7, 6'd3);
    step();
    idle();
    step();
    n_checks++;
    if (px_pos_ret !== 7'd7 || reg_histograma !== 6'd0) begin
      n_fail++;
      $display("FAIL nomatch_col7: got pos=%0d hist=%0d expected pos=7 hist=0", px_pos_ret, reg_histograma);
    end
  endtask

  task automatic test_out_of_range;
    // Continues from back-to-back: col 5 holds 3, outputs show col 7 / 0.
    set_px(1'b1, 1'b1, 7'd85, 6'd4);
    step();
    idle();
    n_checks++;
    if (px_pos_ret !== 7'd7 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_pos: got pos=%0d drop=%b expected pos=7 drop=0", px_pos_ret, drop_err);
    end
    step();
    n_checks++;
    if (px_pos_ret !== 7'd7 || reg_histograma !== 6'd0 || drop_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_hold: got pos=%0d hist=%0d drop=%b busy=%b expected 7 0 0 0",
               px_pos_ret, reg_histograma, drop_err, busy);
    end
    set_px(1'b1, 1'b1, 7'd5, 6'd5);
    step();
    idle();
    step();
    n_checks++;
    if (px_pos_ret !== 7'd5 || reg_histograma !== 6'd4) begin
      n_fail++;
      $display("FAIL oor_col5_intact: got pos=%0d hist=%0d expected pos=5 hist=4", px_pos_ret, reg_histograma);
    end
  endtask

  task automatic test_full_frame;
    int busy_seen;
    int busy_cnt;
    int start_cnt;
    int start_at;
    int hold_err;
    busy_seen = 0;
    busy_cnt  = 0;
    start_cnt = 0;
    start_at  = -1;
    hold_err  = 0;
    apply_reset();
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) begin
        if (busy) busy_seen++;
        set_px(1'b1, (c == 10), 7'(c), 6'(r));
        step();
        if (r == 59 && c == 11) begin
          n_checks++;
          if (reg_histograma !== 6'd60) begin
            n_fail++;
            $display("FAIL frame_col10_count: got %0d expected 60", reg_histograma);
          end
        end
      end
    end
    idle();
    n_checks++;
    if (busy_seen !== 0) begin
      n_fail++;
      $display("FAIL frame_busy_early: got %0d busy samples expected 0", busy_seen);
    end
    // Sample k corresponds to cycle N+k after the last pixel (79,59).
    for (int k = 1; k <= 90; k++) begin
      if (busy) busy_cnt++;
      if (start) begin
        start_cnt++;
        start_at = k;
      end
      if (k >= 2 && (px_pos_ret !== 7'd79 || reg_histograma !== 6'd0)) hold_err++;
      step();
    end
    n_checks++;
    if (start_cnt !== 1 || start_at !== 3) begin
      n_fail++;
      $display("FAIL frame_start: got %0d pulses at N+%0d expected 1 pulse at N+3", start_cnt, start_at);
    end
    n_checks++;
    if (busy_cnt !== 83) begin
      n_fail++;
      $display("FAIL frame_busy_len: got %0d expected 83", busy_cnt);
    end
    n_checks++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL frame_output_hold: got %0d changed samples expected 0", hold_err);
    end
    set_px(1'b1, 1'b1, 7'd10, 6'd0);
    step();
    idle();
    step();
    n_checks++;
    if (px_pos_ret !== 7'd10 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL frame_col10_cleared: got pos=%0d hist=%0d expected pos=10 hist=1",
               px_pos_ret, reg_histograma);
    end
  endtask

  task automatic test_saturation;
    int exp_v;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      set_px(1'b1, 1'b1, 7'd0, 6'(i % 59));
      step();
      if (i >= 1) begin
        exp_v = (i < 63) ? i : 63;
        n_checks++;
        if (reg_histograma !== 6'(exp_v)) begin
          n_fail++;
          $display("FAIL sat_step%0d: got %0d expected %0d", i, reg_histograma, exp_v);
        end
      end
    end
    idle();
    step();
    n_checks++;
    if (reg_histograma !== 6'd63 || px_pos_ret !== 7'd0) begin
      n_fail++;
      $display("FAIL sat_final: got hist=%0d pos=%0d expected hist=63 pos=0", reg_histograma, px_pos_ret);
    end
  endtask

  task automatic test_drop_during_clear;
    int guard;
    apply_reset();
    set_px(1'b1, 1'b1, 7'd3, 6'd0);
    step();
    set_px(1'b1, 1'b1, 7'd3, 6'd1);
    step();
    set_px(1'b1, 1'b1, 7'd79, 6'd59);
    step();
    idle();
    step();
    step();
    n_checks++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_start_pulse: got start=%b busy=%b expected 1 1", start, busy);
    end
    step();
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b1 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_in_clear: got start=%b busy=%b drop=%b expected 0 1 0", start, busy, drop_err);
    end
    set_px(1'b1, 1'b1, 7'd3, 6'd2);
    step();
    idle();
    n_checks++;
    if (drop_err !== 1'b1 || px_pos_ret !== 7'd79 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL drop_flag: got drop=%b pos=%0d hist=%0d expected 1 79 1",
               drop_err, px_pos_ret, reg_histograma);
    end
    step();
    n_checks++;
    if (px_pos_ret !== 7'd79 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL drop_hold: got pos=%0d hist=%0d expected 79 1", px_pos_ret, reg_histograma);
    end
    guard = 0;
    while (busy && guard < 200) begin
      step();
      guard++;
    end
    n_checks++;
    if (busy !== 1'b0 || drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_clear_done: got busy=%b drop=%b expected 0 1", busy, drop_err);
    end
    set_px(1'b1, 1'b1, 7'd3, 6'd0);
    step();
    set_px(1'b1, 1'b1, 7'd79, 6'd0);
    step();
    idle();
    n_checks++;
    if (px_pos_ret !== 7'd79 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL drop_next_col3: got pos=%0d hist=%0d expected 79 1", px_pos_ret, reg_histograma);
    end
    step();
    n_checks++;
    if (reg_histograma !== 6'd1 || drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_next_col79: got hist=%0d drop=%b expected 1 1", reg_histograma, drop_err);
    end
  endtask

  task automatic test_reset_mid_clear;
    // Continues from the drop test, so drop_err starts at 1.
    set_px(1'b1, 1'b1, 7'd50, 6'd1);
    step();
    set_px(1'b1, 1'b1, 7'd50, 6'd2);
    step();
    set_px(1'b1, 1'b1, 7'd70, 6'd3);
    step();
    set_px(1'b1, 1'b0, 7'd79, 6'd59);
    step();
    idle();
    // Now at N+1; CLEAR starts at N+4 with index 0, index 30 at N+34.
    repeat (33) step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_busy: got %b expected 1", busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (px_pos_ret !== 7'd0 || reg_histograma !== 6'd0 || start !== 1'b0 ||
        busy !== 1'b0 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_async_reset: got pos=%0d hist=%0d start=%b busy=%b drop=%b expected all 0",
               px_pos_ret, reg_histograma, start, busy, drop_err);
    end
    step();
    rst = 1'b1;
    step();
    set_px(1'b1, 1'b1, 7'd50, 6'd0);
    step();
    idle();
    n_checks++;
    if (px_pos_ret !== 7'd50) begin
      n_fail++;
      $display("FAIL midclr_pos50: got %0d expected 50", px_pos_ret);
    end
    step();
    n_checks++;
    if (reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL midclr_col50: got %0d expected 1", reg_histograma);
    end
    set_px(1'b1, 1'b1, 7'd70, 6'd1);
    step();
    idle();
    step();
    n_checks++;
    if (px_pos_ret !== 7'd70 || reg_histograma !== 6'd1) begin
      n_fail++;
      $display("FAIL midclr_col70: got pos=%0d hist=%0d expected 70 1", px_pos_ret, reg_histograma);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_full_frame();
    test_saturation();
    test_drop_during_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/col_histogram.md
Name: col_histogram

Overview:
- Upstream neighbour of the centroid/LED stage.
- Consumes the 80x60 raster pixel stream after the colour filter. Keeps one saturating per-column count of matching pixels.
- Streams each updated (column index, count) pair downstream in the timing the centroid stage expects: index first, count one cycle later.
- After the last pixel of a frame, issues a one-cycle start pulse, then clears its counters for the next frame.

Parameters:
- NUM_COLS, 80, columns per frame
- NUM_ROWS, 60, rows per frame
- COL_W, 7, column index width
- ROW_W, 6, row index width
- CNT_W, 6, count width; saturates at 2^CNT_W-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- px_valid  in  1  pixel qualifier for px_match/px_col/px_row
- px_match  in  1  pixel passed the colour filter
- px_col  in  COL_W  pixel column, 0..NUM_COLS-1
- px_row  in  ROW_W  pixel row, 0..NUM_ROWS-1
- px_pos_ret  out  COL_W  column index of the latest accepted pixel
- reg_histograma  out  CNT_W  updated count for that column, one cycle after px_pos_ret
- start  out  1  one-cycle pulse: frame histogram complete
- busy  out  1  high in FLUSH, START and CLEAR
- drop_err  out  1  sticky flag: a valid pixel was dropped

Behaviour:
- Reset (rst low, asynchronous) clears:
  - all counters to 0, state to ACCUM
  - px_pos_ret=0, reg_histograma=0, start=0, busy=0, drop_err=0
- Storage and read-modify-write:
  - Counter array cnt[0..NUM_COLS-1] of CNT_W bits, read combinationally.
  - The update is written on the same edge that accepts the pixel.
  - Back-to-back pixels to the same column therefore need no forwarding. Each sees the prior update.
- Acceptance: a pixel is accepted in ACCUM when px_valid=1 and px_col<NUM_COLS.
  - px_col>=NUM_COLS: ignored, no write, outputs hold, drop_err not set.
- Per accepted pixel at cycle N:
  - new = cnt[col] + px_match, saturating at 2^CNT_W-1.
  - cnt[col] <= new at the end of cycle N.
  - px_pos_ret=col during N+1. reg_histograma=new during N+2, via a two-stage register.
  - Both outputs hold their last values when no pixel is accepted. This is safe because the downstream stage takes a max.
- States:
  - ACCUM:
    - Accepting pixels.
    - An accepted pixel with px_col=NUM_COLS-1 and px_row=NUM_ROWS-1 moves the FSM to FLUSH, after that pixel's update.
  - FLUSH:
    - 2-cycle wait (counter) so the last pixel's reg_histograma reaches the output and is absorbed downstream.
    - Then go to START.
  - START:
    - start=1 for exactly one cycle, i.e. cycle N+3 relative to the last pixel.
    - Then go to CLEAR.
  - CLEAR:
    - 7-bit index runs 0..NUM_COLS-1, writing cnt[idx]=0, one entry per cycle (80 cycles).
    - After idx=NUM_COLS-1, return to ACCUM.
- The output pipeline continues draining during FLUSH. px_pos_ret and reg_histograma do not change in START or CLEAR.
- busy=1 in FLUSH, START and CLEAR.
- Dropped pixels:
  - A px_valid pixel arriving while busy=1 is dropped: no write, no output update.
  - Dropping sets drop_err. drop_err clears only on reset.
- No new frame detection is needed. Counters are already zero on re-entering ACCUM.
- Frame-end pixel with px_match=1: counted normally before FLUSH.
- Reset mid-FLUSH or mid-CLEAR: immediate return to the reset values. A partially cleared array is fully zeroed.

Test Plan:
- Full frame, px_match=1 only at column 10 for all 60 rows:
  - Last update on column 10 gives reg_histograma=60.
  - start pulses exactly once, 3 cycles after pixel (79,59). busy is high for 83 cycles.
- Back-to-back pixels on column 5, px_match=1 x3 (arbitrary order):
  - Outputs px_pos_ret=5, 5, 5 and reg_histograma=1, 2, 3 on consecutive cycles, with the 1-cycle offset.
- 70 matches on column 0 over one frame (repeated col 0, legal rows) → count saturates at 63 and never wraps to 0.
- Pixel with px_valid=1 injected during CLEAR → no output change, drop_err=1 and sticky. The next frame counts from 0 on every column.
- px_col=85 with px_valid=1 → no counter write, outputs unchanged, drop_err stays 0.
- rst low during CLEAR at idx=30 → all outputs 0 immediately, state ACCUM. A subsequent single match at column 50 gives reg_histograma=1.
